uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter: the next generation of the team's fixed 8N1 transmitter. It adds configurable data width, optional odd/even parity, 1 or 2 stop bits, and a per-frame runtime baud divisor. It uses a proper valid/ready handshake instead of "send when data non-zero". It sits between a byte-producing client (FIFO or control FSM) and the board TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
DIV_W, 16, width of the baud divisor input.
DEF_DIV, 5208, divisor used when baud_div < 2 (50 MHz clock, 9600 baud).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-low reset.
baud_div  in  DIV_W  clock cycles per bit; sampled only at frame acceptance.
tx_data  in  DATA_BITS  payload; sampled only at frame acceptance.
tx_valid  in  1  client has a frame to send.
tx_ready  out  1  block can accept a frame.
tx_busy  out  1  a frame is in progress (inverse of tx_ready).
tx_done  out  1  one-cycle pulse when the final stop bit completes.
tx  out  1  serial line, idle high.

Behaviour:
- All outputs are registered.
- Reset (rst = 0 at a clk edge): tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, FSM = IDLE, counters = 0.
- Reset mid-frame aborts the frame immediately. The line returns high the next cycle and no tx_done is generated.
- Handshake: a frame is accepted in the cycle where tx_valid && tx_ready.
  - tx_data and the effective divisor D are latched on acceptance: D = baud_div, or DEF_DIV if baud_div < 2.
  - tx_ready falls in the following cycle.
  - tx_data and baud_div are don't-care while busy.
- FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- Each bit period lasts exactly D cycles, counted by a cycle counter 0..D-1.
  - A bit-end tick fires at count D-1.
  - A bit counter tracks the position within DATA (0..DATA_BITS-1) and within STOP (0..STOP_BITS-1).
- Latency: accept at cycle N means tx = 0 from cycle N+1. The start bit occupies cycles N+1..N+D.
- DATA is sent LSB first.
- Parity bit value:
  - even parity: XOR of the latched data bits;
  - odd parity: the inverse of that XOR.
- STOP drives tx = 1 for STOP_BITS*D cycles.
- Frame length F = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * D cycles, counted from the first low cycle.
- Frame end, in the cycle after the last stop cycle (N+F+1): tx_done = 1, tx_ready = 1, tx_busy = 0.
- Back-to-back: if tx_valid is high in the cycle tx_ready returns, the frame is accepted then. Its start bit begins the next cycle, so the gap between frames is exactly 1 idle-high cycle.
- Simultaneous events: tx_valid asserted together with rst = 0 is ignored; reset dominates.
- Divisor width: the cycle counter is DIV_W bits wide and never wraps past D-1. A baud_div of 0 or 1 is clamped to DEF_DIV, never treated as 1 cycle per bit.
- Illegal parameters (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS not 1 or 2) are rejected at elaboration.

Decomposition:
- Shared package uart_pkg:
  - state encoding ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP;
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - DEF_DIV default;
  - a parity-compute function, reused later by the receiver.
- One sub-module, uart_baud_gen:
  - inputs: clk, rst, a load pulse, the divisor, and an enable;
  - output: a bit-end tick every D cycles;
  - reused by the planned uart_rx_cfg.

Test Plan:
- 8N1, baud_div = 4, tx_data = 0xA5 -> tx per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. tx_done pulses 41 cycles after acceptance (F = 40); tx_ready is low for exactly 40 cycles.
- 8E1 and 8O1, baud_div = 4, 0xA5 -> parity bit is 0 (even) and 1 (odd); F = 44.
- 7-bit data, no parity, 2 stop bits, baud_div = 3, 0x41 -> bits 0, 1,0,0,0,0,0,1, 1,1; F = 30.
- tx_valid held high with 0x55 then 0xAA, baud_div = 2 -> two frames with exactly one idle-high cycle between them; the second frame's tx_data is sampled in the tx_done cycle.
- baud_div = 0 with tx_data = 0x01 -> the bit period is DEF_DIV (5208) cycles; changing baud_div mid-frame has no effect.
- rst pulsed low during DATA bit 3 -> tx = 1 and tx_ready = 1 on the next cycle, no tx_done. A new frame is accepted normally afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default divisor
// and the parity helper used by the transmitter (and later the receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 50 MHz clock, 9600 baud
  localparam int DEF_DIV  = 5208;
  localparam int MAX_BITS = 9;

  // Callers zero-extend narrower payloads, so unused bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: restarts on load, then ticks on the last cycle of every
// D-cycle bit period while enabled.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = en && (cnt == (div_q - ONE));

  // Cycle counter 0..D-1 with the divisor captured at load time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data, optional parity, 1/2 stop
// bits, per-frame baud divisor, valid/ready client handshake.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16,
  parameter int DEF_DIV   = uart_pkg::DEF_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);
  import uart_pkg::*;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  state_t               state;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic [3:0]           bit_cnt;
  logic [DIV_W-1:0]     eff_div;
  logic                 accept;
  logic                 tick;

  // Divisors of 0 or 1 fall back to the default rate instead of 1 cycle/bit.
  assign eff_div = (baud_div < DIV_W'(2)) ? DIV_W'(DEF_DIV) : baud_div;
  assign accept  = (state == ST_IDLE) && tx_valid && tx_ready;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .div  (eff_div),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // Frame sequencer; the payload shifts right so tx always takes bit 1 next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bit_cnt  <= 4'd0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q   <= tx_data;
            par_q    <= parity_bit(MAX_BITS'(tx_data), PARITY == PAR_ODD);
            bit_cnt  <= 4'd0;
            state    <= ST_START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            tx    <= data_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= 4'd0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              data_q  <= data_q >> 1;
              tx      <= data_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            bit_cnt <= 4'd0;
            tx      <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state    <= ST_IDLE;
              bit_cnt  <= 4'd0;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed scoreboard bench for uart_tx_cfg covering 8N1, 8E1, 8O1 and 7N2
// frames, back-to-back handshake, default divisor and mid-frame reset.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vl[4];
  logic [15:0] bd[4];
  logic [7:0]  d0, d1, d2;
  logic [6:0]  d3;
  logic        tx_o[4], rdy[4], bsy[4], dne[4];
  logic        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_div(bd[0]), .tx_data(d0), .tx_valid(vl[0]),
    .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done(dne[0]), .tx(tx_o[0]));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_div(bd[1]), .tx_data(d1), .tx_valid(vl[1]),
    .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done(dne[1]), .tx(tx_o[1]));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_div(bd[2]), .tx_data(d2), .tx_valid(vl[2]),
    .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done(dne[2]), .tx(tx_o[2]));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .baud_div(bd[3]), .tx_data(d3), .tx_valid(vl[3]),
    .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done(dne[3]), .tx(tx_o[3]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [7:0] d, input logic [15:0] b);
    vl[u] = v;
    bd[u] = b;
    case (u)
      0: d0 = d;
      1: d1 = d;
      2: d2 = d;
      default: d3 = d[6:0];
    endcase
  endtask

  // Expected line bits for unit u: start, LSB-first data, parity, stops.
  task automatic push_frame(input int u, input logic [7:0] d);
    int   nbits = (u == 3) ? 7 : 8;
    int   nstop = (u == 3) ? 2 : 1;
    logic x = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(d[i]);
      x = x ^ d[i];
    end
    if (u == 1) exp_q.push_back(x);
    if (u == 2) exp_q.push_back(~x);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
  endtask

  function automatic logic [3:0] flags(input int u);
    return {tx_o[u], rdy[u], bsy[u], dne[u]};
  endfunction

  // Called right after the acceptance edge; ends at the tx_done cycle (hold)
  // or one cycle later after checking the pulse dropped.
  task automatic run_frame(input int u, input int dv, input bit hold);
    logic b;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      repeat (dv) begin
        @(negedge clk);
        chk("tx_bit", {3'd0, tx_o[u]}, {3'd0, b});
        chk("in_frame_flags", {1'b0, rdy[u], bsy[u], dne[u]}, 4'b0010);
      end
    end
    @(negedge clk);
    chk("done_cycle", flags(u), 4'b1101);
    if (!hold) begin
      @(negedge clk);
      chk("done_one_cycle", flags(u), 4'b1100);
    end
  endtask

  // Caller is at a negedge; drives the frame, accepts it, checks it.
  task automatic send(input int u, input logic [7:0] d, input logic [15:0] b,
                      input int dv, input bit hold, input bit keep);
    set_in(u, 1'b1, d, b);
    push_frame(u, d);
    chk("ready_before_accept", {3'd0, rdy[u]}, 4'd1);
    @(posedge clk);
    #1;
    if (!keep) set_in(u, 1'b0, 8'h00, b);
    run_frame(u, dv, hold);
  endtask

  initial begin
    for (int u = 0; u < 4; u++) set_in(u, 1'b0, 8'h00, 16'd4);

    // reset dominates a simultaneous tx_valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b1, 8'hA5, 16'd4);
    @(negedge clk);
    for (int u = 0; u < 4; u++) chk("reset_state", flags(u), 4'b1100);
    set_in(0, 1'b0, 8'h00, 16'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", flags(0), 4'b1100);

    send(0, 8'hA5, 16'd4, 4, 1'b0, 1'b0);
    @(negedge clk);
    send(1, 8'hA5, 16'd4, 4, 1'b0, 1'b0);
    @(negedge clk);
    send(2, 8'hA5, 16'd4, 4, 1'b0, 1'b0);
    @(negedge clk);
    send(3, 8'h41, 16'd3, 3, 1'b0, 1'b0);

    // back-to-back: second payload presented in the tx_done cycle
    @(negedge clk);
    send(0, 8'h55, 16'd2, 2, 1'b1, 1'b1);
    send(0, 8'hAA, 16'd2, 2, 1'b0, 1'b0);

    // divisor 0 clamps to the default; inputs change right after acceptance
    @(negedge clk);
    set_in(0, 1'b1, 8'h01, 16'd0);
    push_frame(0, 8'h01);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 8'hFF, 16'd3);
    run_frame(0, 5208, 1'b0);

    // reset during data bit 3
    @(negedge clk);
    set_in(0, 1'b1, 8'hA5, 16'd4);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 8'h00, 16'd4);
    repeat (17) @(negedge clk);
    chk("data_bit3_before_abort", flags(0), 4'b0010);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_flags", flags(0), 4'b1100);
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("no_done_after_abort", flags(0), 4'b1100);
    end
    send(0, 8'h3C, 16'd5, 5, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
